// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch slice: FSM states, NOP word,
// PC step, default reset PC and a saturating counter helper.
package instruction_fetch_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetchState_t;

  localparam logic [31:0]  NOP_WORD         = 32'h0000_0000;
  localparam int unsigned  PC_STEP          = 4;
  localparam logic [31:0]  DEFAULT_RESET_PC = 32'h0000_0000;

  function automatic logic [31:0] satAdd32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

endpackage

// File: rtl/instruction_fetch_queue.sv
// fetch_queue: QDEPTH-deep synchronous FIFO holding {instruction, pc} pairs.
// Clear has priority over push/pop; the head entry is always presented.
module fetch_queue
  import instruction_fetch_pkg::*;
#(
  parameter  int unsigned QDEPTH = 2,
  parameter  int unsigned DATA_W = 64,
  localparam int unsigned PW     = $clog2(QDEPTH),
  localparam int unsigned CW     = PW + 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] pushData,
  input  logic              pop,
  input  logic              clear,
  output logic [CW-1:0]     count,
  output logic [DATA_W-1:0] headData
);

  // Entries reset to a NOP word with a zero PC (instruction in the upper 32 bits).
  localparam logic [DATA_W-1:0] RESET_ENTRY = {NOP_WORD, {(DATA_W-32){1'b0}}};

  logic [DATA_W-1:0] mem [QDEPTH];
  logic [PW-1:0]     rdPtr;
  logic [PW-1:0]     wrPtr;

  // Storage, pointers and occupancy count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < QDEPTH; i++) mem[i] <= RESET_ENTRY;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else if (clear) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + 1'b1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign headData = mem[rdPtr];

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC/FSM/credit logic issuing 1-cycle-latency word reads,
// buffering returns in fetch_queue and draining them over valid/ready.
// Optional performance counters are built when IFETCH_PERF_EN is defined.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = ADDR_W'(DEFAULT_RESET_PC),
  parameter int unsigned        QDEPTH   = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instruction,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_flushed,
  output logic [31:0]       perf_stall
`endif
);

  localparam int unsigned CW = $clog2(QDEPTH) + 1;

  fetchState_t        state;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  reqPc;
  logic               epoch;
  logic               reqEpoch;
  logic               inflight;
  logic [CW-1:0]      count;
  logic [ADDR_W+31:0] headData;
  logic [CW:0]        used;
  logic               accept;
  logic               push;
  logic               dropResp;
  logic [ADDR_W-1:0]  target;
  logic               unusedLowBits;

  assign unusedLowBits = ^redirect_pc[1:0];
  assign target        = {redirect_pc[ADDR_W-1:2], 2'b00};
  assign instr_valid   = (count != '0);
  assign accept        = instr_valid && instr_ready;
  assign imem_addr     = pc;
  assign instruction   = headData[ADDR_W+31:ADDR_W];
  assign instr_pc      = headData[ADDR_W-1:0];

  // Credit check and response filtering. The slot freed by a same-cycle pop is
  // credited immediately so a full-rate stream sustains one word per cycle.
  always_comb begin
    used     = (CW+1)'(count) + (CW+1)'(inflight) - (CW+1)'(accept);
    imem_req = (state == RUN) && (used < (CW+1)'(QDEPTH)) && !redirect;
    push     = imem_rvalid && inflight && (reqEpoch == epoch) && !redirect;
    dropResp = imem_rvalid && inflight && !push;
  end

  // FSM, PC, epoch and outstanding-request tracking.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      reqPc    <= '0;
      epoch    <= 1'b0;
      reqEpoch <= 1'b0;
      inflight <= 1'b0;
    end else begin
      case (state)
        BOOT:    state <= RUN;
        RUN:     state <= RUN;
        default: state <= BOOT;
      endcase
      if (redirect) begin
        pc    <= target;
        epoch <= ~epoch;
      end else if (imem_req) begin
        pc <= pc + ADDR_W'(PC_STEP);
      end
      inflight <= imem_req;
      if (imem_req) begin
        reqPc    <= pc;
        reqEpoch <= epoch;
      end
    end
  end

  fetch_queue #(
    .QDEPTH (QDEPTH),
    .DATA_W (ADDR_W + 32)
  ) u_queue (
    .clk      (clk),
    .reset_n  (reset_n),
    .push     (push),
    .pushData ({imem_rdata, reqPc}),
    .pop      (accept && !redirect),
    .clear    (redirect),
    .count    (count),
    .headData (headData)
  );

`ifdef IFETCH_PERF_EN
  // Saturating counters: words pushed, words discarded by redirect, idle RUN cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
      perf_stall   <= '0;
    end else begin
      perf_fetched <= satAdd32(perf_fetched, 32'(push));
      perf_flushed <= satAdd32(perf_flushed,
                               (redirect ? 32'(count) : 32'd0) + 32'(dropResp));
      perf_stall   <= satAdd32(perf_stall,
                               32'((state == RUN) && !imem_req && !redirect));
    end
  end
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: echo memory (rdata = addr),
// scoreboard of expected PCs refilled on reset/redirect, directed timing checks.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic [31:0] instr_pc;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef IFETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_flushed;
  logic [31:0] perf_stall;
`endif

  int unsigned assertCount = 0;
  int unsigned failCount   = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  instruction_fetch #(
    .ADDR_W   (32),
    .RESET_PC (32'h0000_0000),
    .QDEPTH   (2)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .instr_pc    (instr_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
`ifdef IFETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_flushed (perf_flushed),
    .perf_stall   (perf_stall)
`endif
  );

  // Instruction memory: answers one cycle after a request with the address as data.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      imem_rvalid <= 1'b0;
      imem_rdata  <= '0;
    end else begin
      imem_rvalid <= imem_req;
      imem_rdata  <= imem_addr;
    end
  end

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    assertCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic refill(input logic [31:0] start);
    sb.delete();
    for (int i = 0; i < 64; i++) sb.push_back(start + 32'(i * 4));
  endtask

  // Compare every accepted head against the expected PC stream.
  task automatic settle();
    logic [31:0] exp;
    #1;
    if (reset_n && instr_valid && instr_ready && !redirect) begin
      if (sb.size() == 0) begin
        checkEq("sb_underflow", instr_pc, 32'hDEAD_BEEF);
      end else begin
        exp = sb.pop_front();
        checkEq("sb_pc", instr_pc, exp);
        checkEq("sb_instr", instruction, exp);
      end
    end
  endtask

  task automatic nextCycle();
    @(negedge clk);
  endtask

  task automatic cycle();
    settle();
    nextCycle();
  endtask

  task automatic waitValid(input string tag, input int unsigned maxCycles);
    bit seen = 0;
    for (int unsigned i = 0; i < maxCycles; i++) begin
      settle();
      if (instr_valid) begin
        seen = 1;
        break;
      end
      nextCycle();
    end
    checkEq(tag, 32'(seen), 32'd1);
    if (seen) nextCycle();
  endtask

  task automatic resetDut();
    @(negedge clk);
    reset_n     = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    #1;
    checkEq("rst_valid", 32'(instr_valid), 32'd0);
    checkEq("rst_req", 32'(imem_req), 32'd0);
`ifdef IFETCH_PERF_EN
    checkEq("rst_perf_fetched", perf_fetched, 32'd0);
    checkEq("rst_perf_flushed", perf_flushed, 32'd0);
`endif
    refill(32'h0);
    nextCycle();
    nextCycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    instr_ready = 1'b1;
    redirect    = 1'b0;
    redirect_pc = '0;

    // 1: boot timing and full-rate stream.
    resetDut();
    checkEq("rst_instr", instruction, 32'h0);
    checkEq("rst_pc", instr_pc, 32'h0);
    reset_n = 1'b1;
    settle(); checkEq("t1_boot_req", 32'(imem_req), 32'd0); nextCycle();
    settle(); checkEq("t1_first_req", 32'(imem_req), 32'd1);
    checkEq("t1_first_addr", imem_addr, 32'h0); nextCycle();
    settle(); checkEq("t1_not_yet_valid", 32'(instr_valid), 32'd0); nextCycle();
    settle(); checkEq("t1_first_valid", 32'(instr_valid), 32'd1); nextCycle();
    for (int i = 0; i < 6; i++) begin
      settle(); checkEq("t1_throughput", 32'(instr_valid), 32'd1); nextCycle();
    end

    // 2: backpressure fills the queue with exactly two words.
    resetDut();
    reset_n     = 1'b1;
    instr_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      settle();
      if (i >= 3) begin
        checkEq("t2_hold_valid", 32'(instr_valid), 32'd1);
        checkEq("t2_hold_pc", instr_pc, 32'h0);
        checkEq("t2_hold_instr", instruction, 32'h0);
        checkEq("t2_no_req", 32'(imem_req), 32'd0);
      end
      nextCycle();
    end
    instr_ready = 1'b1;
    settle(); checkEq("t2_release_addr", imem_addr, 32'h8);
    checkEq("t2_release_req", 32'(imem_req), 32'd1); nextCycle();
    settle(); checkEq("t2_no_gap1", 32'(instr_valid), 32'd1); nextCycle();
    settle(); checkEq("t2_no_gap2", 32'(instr_valid), 32'd1); nextCycle();
    repeat (3) cycle();

    // 3: redirect with a request in flight; low address bits ignored.
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    settle(); checkEq("t3_req_in_N", 32'(imem_req), 32'd0);
    refill(32'h100); nextCycle();
    redirect = 1'b0;
    settle(); checkEq("t3_addr_N1", imem_addr, 32'h100);
    checkEq("t3_req_N1", 32'(imem_req), 32'd1);
    checkEq("t3_flushed_N1", 32'(instr_valid), 32'd0); nextCycle();
    waitValid("t3_target_valid", 6);
    repeat (4) cycle();
`ifdef IFETCH_PERF_EN
    checkEq("t3_perf_flushed_nz", 32'(perf_flushed != 0), 32'd1);
`endif

    // 4: back-to-back redirects, last one wins.
    redirect = 1'b1; redirect_pc = 32'h200;
    settle(); nextCycle();
    redirect_pc = 32'h300;
    settle(); checkEq("t4_req_N1", 32'(imem_req), 32'd0);
    refill(32'h300); nextCycle();
    redirect = 1'b0;
    settle(); checkEq("t4_addr", imem_addr, 32'h300); nextCycle();
    waitValid("t4_target_valid", 6);
    repeat (4) cycle();

    // 5: PC wraps from the top of the address space.
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    settle(); refill(32'hFFFF_FFFC); nextCycle();
    redirect = 1'b0;
    settle(); checkEq("t5_top_addr", imem_addr, 32'hFFFF_FFFC); nextCycle();
    settle(); checkEq("t5_wrap_addr", imem_addr, 32'h0); nextCycle();
    waitValid("t5_valid", 6);
    repeat (4) cycle();

    // 6: asynchronous reset with a full queue, then restart.
    instr_ready = 1'b0;
    repeat (4) cycle();
    checkEq("t6_full_valid", 32'(instr_valid), 32'd1);
    reset_n = 1'b0;
    #1;
    checkEq("t6_async_valid", 32'(instr_valid), 32'd0);
    checkEq("t6_async_req", 32'(imem_req), 32'd0);
    instr_ready = 1'b1;
    resetDut();
    reset_n = 1'b1;
    settle(); nextCycle();
    settle(); checkEq("t6_restart_addr", imem_addr, 32'h0); nextCycle();
    waitValid("t6_restart_valid", 6);
    repeat (4) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
